// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back, write-allocate data cache for the MEM stage.
// Misses run an optional line write-back followed by a refill over a registered req/ack handshake.
module dcache_ctrl #(
    parameter int LINE_ADDR_LEN = 2,
    parameter int SET_ADDR_LEN  = 3
) (
    input  logic                                clk,
    input  logic                                CpuRst,
    input  logic [31:0]                         Addr,
    input  logic                                RdReq,
    input  logic                                WrReq,
    input  logic [3:0]                          WrByteEn,
    input  logic [31:0]                         WrData,
    input  logic                                StallM,
    output logic [31:0]                         RdData,
    output logic                                DCacheMiss,
    output logic                                MemReq,
    output logic                                MemWe,
    output logic [31:0]                         MemAddr,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]    MemWrLine,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]    MemRdLine,
    input  logic                                MemAck,
    output logic [31:0]                         HitCount,
    output logic [31:0]                         MissCount
);
    localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int SETS = 2 ** SET_ADDR_LEN;
    localparam int LINE_W = 32 * (2 ** LINE_ADDR_LEN);
    localparam logic [1:0] IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2;

    logic [LINE_ADDR_LEN-1:0] word_off;
    logic [SET_ADDR_LEN-1:0]  idx;
    logic [TAG_ADDR_LEN-1:0]  tag;
    logic                     unused_addr;
    logic                     req, hit;
    logic [LINE_W-1:0]        line;
    logic [31:0]              cur_word, merged_word;

    logic [1:0]               state_q, state_d;
    logic [SETS-1:0]          valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_ADDR_LEN-1:0]  tag_q [SETS];
    logic [TAG_ADDR_LEN-1:0]  tag_d [SETS];
    logic [LINE_W-1:0]        data_q [SETS];
    logic [LINE_W-1:0]        data_d [SETS];
    logic                     mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]              mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]        mem_wr_line_q, mem_wr_line_d;
    logic [31:0]              hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    logic                     just_refilled_q, just_refilled_d;

    assign word_off    = Addr[LINE_ADDR_LEN+1:2];
    assign idx         = Addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign tag         = Addr[31:LINE_ADDR_LEN+SET_ADDR_LEN+2];
    assign unused_addr = ^Addr[1:0];
    assign req         = RdReq | WrReq;
    assign hit         = valid_q[idx] && (tag_q[idx] == tag);
    assign line        = data_q[idx];
    assign cur_word    = line[{word_off, 5'b0} +: 32];

    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++)
            merged_word[b*8 +: 8] = WrByteEn[b] ? WrData[b*8 +: 8] : cur_word[b*8 +: 8];
    end

    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        tag_d           = tag_q;
        data_d          = data_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wr_line_d   = mem_wr_line_q;
        miss_count_d    = miss_count_q;
        just_refilled_d = 1'b0;
        // The first cycle after a refill is the replayed access, not a new hit.
        hit_count_d     = hit_count_q + 32'(state_q == IDLE && req && hit && !StallM && !just_refilled_q);
        case (state_q)
            IDLE: begin
                if (req && hit && WrReq) begin
                    data_d[idx][{word_off, 5'b0} +: 32] = merged_word;
                    dirty_d[idx] = 1'b1;
                end else if (req && !hit) begin
                    miss_count_d = miss_count_q + 32'd1;
                    mem_req_d    = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d       = WRITEBACK;
                        mem_we_d      = 1'b1;
                        mem_addr_d    = {tag_q[idx], idx, {(LINE_ADDR_LEN+2){1'b0}}};
                        mem_wr_line_d = line;
                    end else begin
                        state_d    = REFILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {tag, idx, {(LINE_ADDR_LEN+2){1'b0}}};
                    end
                end
            end
            WRITEBACK: begin
                if (MemAck) begin
                    state_d    = REFILL;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {tag, idx, {(LINE_ADDR_LEN+2){1'b0}}};
                end
            end
            REFILL: begin
                if (MemAck) begin
                    data_d[idx]     = MemRdLine;
                    valid_d[idx]    = 1'b1;
                    dirty_d[idx]    = 1'b0;
                    tag_d[idx]      = tag;
                    state_d         = IDLE;
                    mem_req_d       = 1'b0;
                    just_refilled_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (CpuRst) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wr_line_q   <= '0;
            hit_count_q     <= '0;
            miss_count_q    <= '0;
            just_refilled_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wr_line_q   <= mem_wr_line_d;
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
            just_refilled_q <= just_refilled_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign RdData     = cur_word;
    assign DCacheMiss = (state_q != IDLE) || (req && !hit);
    assign MemReq     = mem_req_q;
    assign MemWe      = mem_we_q;
    assign MemAddr    = mem_addr_q;
    assign MemWrLine  = mem_wr_line_q;
    assign HitCount   = hit_count_q;
    assign MissCount  = miss_count_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed vectors and hand-written miss sequences for dcache_ctrl.
module tb_dcache_ctrl;
    logic         clk = 1'b0;
    logic         CpuRst, RdReq, WrReq, StallM, MemAck;
    logic [31:0]  Addr, WrData, RdData, MemAddr, HitCount, MissCount;
    logic [3:0]   WrByteEn;
    logic         DCacheMiss, MemReq, MemWe;
    logic [127:0] MemWrLine, MemRdLine;
    int           checks = 0;
    int           failures = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [8];

    localparam logic [127:0] LINE0 = 128'h44443333_33332222_22221111_11110000;
    localparam logic [127:0] LINE1 = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
    localparam logic [127:0] EVICT = 128'h44443333_12332222_DEADABEF_11110000;

    dcache_ctrl dut (
        .clk(clk), .CpuRst(CpuRst), .Addr(Addr), .RdReq(RdReq), .WrReq(WrReq),
        .WrByteEn(WrByteEn), .WrData(WrData), .StallM(StallM), .RdData(RdData),
        .DCacheMiss(DCacheMiss), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWrLine(MemWrLine), .MemRdLine(MemRdLine), .MemAck(MemAck),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        RdReq = 0; WrReq = 0; WrByteEn = 0; WrData = 0; StallM = 0; MemAck = 0; Addr = 0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32'h44, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h44, 4'h0, 32'h0, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 1'b1, 32'h44, 4'h2, 32'h0000AB00, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h44, 4'h0, 32'h0, 32'hDEADABEF};
        tbl[4] = '{1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 32'h11110000};
        tbl[5] = '{1'b0, 1'b1, 32'h48, 4'h8, 32'h12000000, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 32'h48, 4'h0, 32'h0, 32'h12332222};
        tbl[7] = '{1'b1, 1'b0, 32'h4C, 4'h0, 32'h0, 32'h44443333};
        idle_in();
        MemRdLine = '0;
        CpuRst = 1;
        cyc(); cyc();
        CpuRst = 0;
        cyc();
        chk("rst_memreq", 128'(MemReq), 128'd0);
        chk("rst_miss", 128'(DCacheMiss), 128'd0);
        chk("rst_memaddr", 128'(MemAddr), 128'd0);
        chk("rst_hits", 128'(HitCount), 128'd0);
        chk("rst_misses", 128'(MissCount), 128'd0);

        // Clean miss on 0x40, ack in cycle 4
        RdReq = 1; Addr = 32'h40;
        #1 chk("c0_miss", 128'(DCacheMiss), 128'd1);
        chk("c0_memreq", 128'(MemReq), 128'd0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            MemAck = (c == 4);
            MemRdLine = (c == 4) ? LINE0 : '0;
            #1 chk("refill_req", 128'(MemReq), 128'd1);
            chk("refill_we", 128'(MemWe), 128'd0);
            chk("refill_addr", 128'(MemAddr), 128'h40);
            chk("refill_stall", 128'(DCacheMiss), 128'd1);
        end
        cyc();
        MemAck = 0; MemRdLine = '0;
        #1 chk("c5_miss", 128'(DCacheMiss), 128'd0);
        chk("c5_rdata", 128'(RdData), 128'h11110000);
        chk("c5_memreq", 128'(MemReq), 128'd0);
        chk("c5_misses", 128'(MissCount), 128'd1);
        chk("c5_hits", 128'(HitCount), 128'd0);

        for (int i = 0; i < 8; i++) begin
            cyc();
            RdReq = tbl[i].rd; WrReq = tbl[i].wr; Addr = tbl[i].addr;
            WrByteEn = tbl[i].be; WrData = tbl[i].wdata;
            #1 chk("vec_hits", 128'(HitCount), 128'(i));
            chk("vec_miss", 128'(DCacheMiss), 128'd0);
            if (tbl[i].rd) chk("vec_rdata", 128'(RdData), 128'(tbl[i].exp));
        end
        cyc();
        idle_in();
        #1 chk("tbl_hits", 128'(HitCount), 128'd8);

        // Dirty eviction: 0xC0 shares the set with 0x40
        RdReq = 1; Addr = 32'hC0;
        #1 chk("ev_miss", 128'(DCacheMiss), 128'd1);
        cyc();
        #1 chk("wb_req", 128'(MemReq), 128'd1);
        chk("wb_we", 128'(MemWe), 128'd1);
        chk("wb_addr", 128'(MemAddr), 128'h40);
        chk("wb_line", MemWrLine, EVICT);
        chk("wb_misses", 128'(MissCount), 128'd2);
        cyc();
        MemAck = 1;
        #1 chk("wb_ack_we", 128'(MemWe), 128'd1);
        cyc();
        MemAck = 0;
        #1 chk("rf_req", 128'(MemReq), 128'd1);
        chk("rf_we", 128'(MemWe), 128'd0);
        chk("rf_addr", 128'(MemAddr), 128'hC0);
        chk("rf_stall", 128'(DCacheMiss), 128'd1);
        cyc();
        MemAck = 1; MemRdLine = LINE1;
        cyc();
        MemAck = 0; MemRdLine = '0;
        #1 chk("ev_done_miss", 128'(DCacheMiss), 128'd0);
        chk("ev_rdata", 128'(RdData), 128'hDDDD0000);
        chk("ev_misses", 128'(MissCount), 128'd2);

        // Held load: only the unstalled cycle counts
        for (int c = 0; c < 3; c++) begin
            cyc();
            Addr = 32'hC4; StallM = (c < 2);
            #1 chk("hold_rdata", 128'(RdData), 128'hDDDD0001);
            chk("hold_miss", 128'(DCacheMiss), 128'd0);
        end
        cyc();
        idle_in();
        #1 chk("hold_hits", 128'(HitCount), 128'd9);

        // Reset in the middle of a refill of 0x100
        RdReq = 1; Addr = 32'h100;
        cyc();
        #1 chk("mid_req", 128'(MemReq), 128'd1);
        chk("mid_addr", 128'(MemAddr), 128'h100);
        CpuRst = 1;
        cyc();
        CpuRst = 0; RdReq = 0;
        #1 chk("mid_memreq", 128'(MemReq), 128'd0);
        chk("mid_miss", 128'(DCacheMiss), 128'd0);
        chk("mid_misses", 128'(MissCount), 128'd0);
        chk("mid_hits", 128'(HitCount), 128'd0);
        RdReq = 1; Addr = 32'hC0;
        #1 chk("post_rst_c0", 128'(DCacheMiss), 128'd1);
        Addr = 32'h40;
        #1 chk("post_rst_40", 128'(DCacheMiss), 128'd1);
        RdReq = 0;
        cyc();
        #1 chk("post_rst_memreq", 128'(MemReq), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
